// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: row-scanning matrix keypad reader with press/release debounce and key-code history
module keypad_scan_debounce #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SETTLE = 2,
  parameter int DEBOUNCE = 8,
  parameter int DIGITS = 2,
  localparam int KW = $clog2(ROWS*COLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COLS-1:0]      col_sync,
  output logic [ROWS-1:0]      r_sel,
  output logic [KW-1:0]        key_code,
  output logic                 key_valid,
  output logic                 key_held,
  output logic                 multi_err,
  output logic [DIGITS*KW-1:0] digits
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(SETTLE) + 1;
  localparam int DW = $clog2(DEBOUNCE) + 1;
  localparam int DK = DIGITS * KW;
  localparam logic [1:0] SCAN = 2'd0, BOUNCE = 2'd1, HELD = 2'd2, RELEASE = 2'd3;
  logic [1:0] state;
  logic [RW-1:0] row, row_nxt;
  logic [SW-1:0] cnt;
  logic [DW-1:0] dcnt;
  logic [COLS-1:0] pat;
  logic [CW-1:0] idx;
  logic [KW-1:0] code;
  logic zero, one_hot, sample, take, advance;
  always_comb begin
    row_nxt = row == RW'(ROWS-1) ? '0 : row + RW'(1);
    zero = col_sync == '0;
    one_hot = !zero && (col_sync & (col_sync - COLS'(1))) == '0;
    idx = '0;
    for (int c = 0; c < COLS; c++) if (col_sync[c]) idx = CW'(c);
    code = KW'(row) * KW'(COLS) + KW'(idx);
    sample = cnt == SW'(SETTLE-1);
    take = !zero && ((state == SCAN && sample && DEBOUNCE == 1) ||
                     (state == BOUNCE && col_sync == pat && dcnt == DW'(DEBOUNCE-1)));
    // every exit back to SCAN moves on to the next row
    advance = zero && ((state == SCAN && sample) || state == BOUNCE ||
                       (state == HELD && DEBOUNCE == 1) ||
                       (state == RELEASE && dcnt == DW'(DEBOUNCE-1)));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCAN;
      row <= '0;
      cnt <= '0;
      dcnt <= '0;
      pat <= '0;
      r_sel <= ~ROWS'(1);
      key_code <= '0;
      digits <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      multi_err <= 1'b0;
      case (state)
        SCAN: begin
          cnt <= sample ? '0 : cnt + SW'(1);
          if (sample && !zero) begin
            pat <= col_sync;
            dcnt <= DW'(1);
            state <= BOUNCE;
          end
        end
        BOUNCE: begin
          pat <= col_sync;
          dcnt <= col_sync == pat ? dcnt + DW'(1) : DW'(1);
        end
        HELD: if (zero) begin
          state <= RELEASE;
          dcnt <= DW'(1);
        end
        RELEASE: begin
          state <= zero ? RELEASE : HELD;
          dcnt <= dcnt + DW'(1);
        end
        default: state <= SCAN;
      endcase
      if (take) begin
        state <= HELD;
        if (one_hot) begin
          key_code <= code;
          digits <= DK'({digits, code});
          key_valid <= 1'b1;
          key_held <= 1'b1;
        end else multi_err <= 1'b1;
      end
      if (advance) begin
        state <= SCAN;
        row <= row_nxt;
        r_sel <= ~(ROWS'(1) << row_nxt);
        cnt <= '0;
        key_held <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb_keypad_scan_debounce: directed keypad scenarios checked against a run-length behavioural model
module tb_keypad_scan_debounce;
  localparam int ROWS = 4, COLS = 4, SETTLE = 2, DB = 8, KW = 4;
  logic clk = 0, reset = 1;
  logic [3:0] col_sync, r_sel, key_code;
  logic key_valid, key_held, multi_err;
  logic [7:0] digits;
  logic [4:0] col2;
  logic [2:0] r_sel2;
  logic [3:0] key_code2;
  logic kv2, kh2, me2;
  logic [7:0] digits2;
  logic key_on = 0, force_on = 0, key2_on = 0;
  int key_r = 0;
  logic [3:0] key_pat = '0, force_val = '0;
  assign col_sync = force_on ? force_val : (key_on && !r_sel[key_r]) ? key_pat : 4'd0;
  assign col2 = (key2_on && !r_sel2[2]) ? 5'b10000 : 5'b00000;
  always #5 clk = ~clk;

  keypad_scan_debounce dut (
    .clk(clk), .reset(reset), .col_sync(col_sync), .r_sel(r_sel), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .multi_err(multi_err), .digits(digits));

  keypad_scan_debounce #(.ROWS(3), .COLS(5), .DEBOUNCE(1)) dut2 (
    .clk(clk), .reset(reset), .col_sync(col2), .r_sel(r_sel2), .key_code(key_code2),
    .key_valid(kv2), .key_held(kh2), .multi_err(me2), .digits(digits2));

  int n_chk = 0, n_fail = 0, kv_cnt = 0, me_cnt = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: mode 0 scanning, 1 counting a pressed run, 2 key down, 3 counting a released run
  int m_mode, m_row, m_ph, m_run;
  logic [3:0] m_pat, m_code;
  bit m_kv, m_me, m_held, live = 0;
  logic [3:0] hist[$];
  logic [3:0] smp;
  logic srst;

  task automatic next_row();
    m_mode = 0;
    m_ph = 0;
    m_row = (m_row + 1) % ROWS;
  endtask
  task automatic press(input logic [3:0] s);
    int i = 0;
    if ($countones(s) == 1) begin
      while ((s >> i) != 4'd1) i++;
      m_code = 4'(m_row * COLS + i);
      hist.push_front(m_code);
      void'(hist.pop_back());
      m_kv = 1;
      m_held = 1;
    end else m_me = 1;
    m_mode = 2;
  endtask
  task automatic unpress();
    m_held = 0;
    next_row();
  endtask
  task automatic model_step(input logic [3:0] s);
    m_kv = 0;
    m_me = 0;
    case (m_mode)
      0: if (m_ph < SETTLE - 1) m_ph++;
         else if (s == 0) next_row();
         else begin
           m_ph = 0; m_pat = s; m_run = 1; m_mode = 1;
           if (m_run == DB) press(s);
         end
      1: if (s == 0) next_row();
         else if (s != m_pat) begin m_pat = s; m_run = 1; end
         else begin m_run++; if (m_run == DB) press(s); end
      2: if (s == 0) begin m_run = 1; m_mode = 3; if (m_run == DB) unpress(); end
      default: if (s != 0) m_mode = 2;
               else begin m_run++; if (m_run == DB) unpress(); end
    endcase
  endtask

  initial begin : model
    logic [3:0] e_rsel;
    forever begin
      @(negedge clk);
      smp = col_sync;
      srst = reset;
      @(posedge clk);
      #1;
      if (srst) begin
        m_mode = 0; m_row = 0; m_ph = 0; m_run = 0; m_pat = 0; m_code = 0;
        m_kv = 0; m_me = 0; m_held = 0; hist = '{4'd0, 4'd0}; live = 1;
      end else if (live) model_step(smp);
      if (live) begin
        e_rsel = ~(4'd1 << m_row);
        check("r_sel", r_sel, e_rsel);
        check("key_code", key_code, m_code);
        check("key_valid", key_valid, m_kv);
        check("key_held", key_held, m_held);
        check("multi_err", multi_err, m_me);
        check("digits", digits, {hist[1], hist[0]});
        kv_cnt += int'(key_valid);
        me_cnt += int'(multi_err);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic do_reset();
    reset = 1;
    step(2);
    reset = 0;
  endtask
  task automatic wait_held(input bit v, input string name);
    int k = 0;
    while (key_held !== v && k < 60) begin step(); k++; end
    check({name, " key_held"}, key_held, v);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] exp_scan [8] = '{4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b1110};
    int kv0, me0;
    step(3);
    reset = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("idle scan r_sel", r_sel, exp_scan[k]);
    end
    step(32);
    check("idle key_valid count", kv_cnt, 0);
    check("idle multi_err count", me_cnt, 0);
    check("idle key_held", key_held, 0);

    kv0 = kv_cnt;
    key_r = 2; key_pat = 4'b0010; key_on = 1;
    step(30);
    check("r2c1 pulses", kv_cnt - kv0, 1);
    check("r2c1 key_code", key_code, 9);
    check("r2c1 digits", digits, 8'h09);
    check("r2c1 key_held", key_held, 1);
    key_on = 0;
    step(7);
    check("r2c1 held before debounce", key_held, 1);
    step(1);
    check("r2c1 held after debounce", key_held, 0);
    check("r2c1 resume row3", r_sel, 4'b0111);

    do_reset();
    check("reset digits", digits, 0);
    key_r = 1; key_pat = 4'b0010; key_on = 1;
    wait_held(1, "press5");
    check("press5 key_valid", key_valid, 1);
    check("press5 key_code", key_code, 5);
    check("press5 digits", digits, 8'h05);
    key_on = 0;
    wait_held(0, "release5");
    key_r = 3; key_pat = 4'b0001; key_on = 1;
    wait_held(1, "press12");
    check("press12 key_code", key_code, 12);
    check("press12 digits", digits, 8'h5C);
    key_on = 0;
    wait_held(0, "release12");

    do_reset();
    kv0 = kv_cnt; me0 = me_cnt;
    force_val = 4'b0001; force_on = 1;
    step(5);
    check("bounce row held", r_sel, 4'b1110);
    force_on = 0;
    step(1);
    check("bounce resume row1", r_sel, 4'b1101);
    check("bounce no key_valid", kv_cnt - kv0, 0);
    check("bounce no multi_err", me_cnt - me0, 0);

    do_reset();
    kv0 = kv_cnt;
    key_r = 0; key_pat = 4'b0100; key_on = 1;
    wait_held(1, "relbounce press");
    key_on = 0; step(3);
    key_on = 1; step(1);
    key_on = 0; step(7);
    check("relbounce still held", key_held, 1);
    step(1);
    check("relbounce released", key_held, 0);
    check("relbounce single pulse", kv_cnt - kv0, 1);

    me0 = me_cnt;
    key_r = 1; key_pat = 4'b0110; key_on = 1;
    for (int k = 0; k < 60 && !multi_err; k++) step();
    check("multi multi_err", multi_err, 1);
    check("multi key_valid", key_valid, 0);
    check("multi key_code", key_code, 2);
    check("multi digits", digits, 8'h02);
    check("multi key_held", key_held, 0);
    step(10);
    check("multi single pulse", me_cnt - me0, 1);
    key_on = 0;
    step(12);

    key_r = 2; key_pat = 4'b1000; key_on = 1;
    wait_held(1, "press11");
    check("press11 key_code", key_code, 11);
    reset = 1;
    step(1);
    check("midheld reset r_sel", r_sel, 4'b1110);
    check("midheld reset key_code", key_code, 0);
    check("midheld reset digits", digits, 0);
    check("midheld reset key_valid", key_valid, 0);
    check("midheld reset key_held", key_held, 0);
    check("midheld reset multi_err", multi_err, 0);
    reset = 0;
    wait_held(1, "repress11");
    check("repress11 key_code", key_code, 11);
    check("repress11 digits", digits, 8'h0B);
    key_on = 0;
    wait_held(0, "release11");

    do_reset();
    key2_on = 1;
    step(5);
    check("db1 no early pulse", kv2, 0);
    step(1);
    check("db1 key_valid", kv2, 1);
    check("db1 key_code", key_code2, 14);
    check("db1 key_held", kh2, 1);
    check("db1 row2", r_sel2, 3'b011);
    step(1);
    check("db1 pulse width", kv2, 0);
    key2_on = 0;
    step(1);
    check("db1 release", kh2, 0);
    check("db1 wrap row0", r_sel2, 3'b110);
    check("db1 no multi_err", me2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Parametrised matrix-keypad scanner for the keypad-to-display path. It drives one active-low row at a time and samples the synchronised column inputs. Each press is debounced on both press and release, and each debounced single-key press is reported once as a linear key code with a one-cycle valid pulse. Accepted codes are shifted into a DIGITS-deep history that feeds the segment-display mux. Multi-key presses are flagged and never enter the history.

## Interface
Parameters:
- ROWS, 4, number of keypad rows driven (≥2)
- COLS, 4, number of keypad columns sampled (≥2)
- SETTLE, 2, cycles each row is driven before its columns are sampled (≥1)
- DEBOUNCE, 8, consecutive identical samples required on press and on release (≥1)
- DIGITS, 2, depth of the key-code history (≥1)
- KW (derived), $clog2(ROWS*COLS), key-code width

Ports:
- clk  in  1  single clock; all state updates on posedge clk
- reset  in  1  synchronous, active-high reset
- col_sync  in  COLS  already-synchronised columns, active-high (bit c set = a key in column c conducts to the driven row)
- r_sel  out  ROWS  row drive, active-low, exactly one bit low at all times
- key_code  out  KW  last accepted key, row*COLS+col
- key_valid  out  1  one-cycle pulse when key_code and digits update
- key_held  out  1  high while an accepted single key remains pressed
- multi_err  out  1  one-cycle pulse on a debounced multi-column press
- digits  out  DIGITS*KW  history; slice [KW-1:0] newest, higher slices older

## Operation
- States: SCAN, DEBOUNCE, HELD, RELEASE. Row index `row` is in 0..ROWS-1. r_sel = ~(1<<row) in every state.
- SCAN:
  - Settle counter runs 0..SETTLE-1.
  - At count SETTLE-1, sample col_sync.
  - Sample zero: row advances with wrap from ROWS-1 to 0, and the counter clears.
  - Sample nonzero: capture the pattern into `pat`, set the debounce count to 1, go to DEBOUNCE. If DEBOUNCE=1, evaluate acceptance immediately instead.
- DEBOUNCE (row held):
  - col_sync==pat: increment the count.
  - col_sync==0: abort; return to SCAN at row+1 (wrapped) with no outputs.
  - Nonzero and ≠pat: recapture pat and set the count to 1.
- Acceptance, when the count reaches DEBOUNCE:
  - pat one-hot: key_code ← row*COLS + index(pat), shift digits by one slot (oldest dropped, newest in slice 0), pulse key_valid, set key_held, go to HELD.
  - pat not one-hot: pulse multi_err, leave key_code and digits unchanged, key_held stays 0, go to HELD.
- HELD: stay while col_sync≠0. On col_sync==0, go to RELEASE with the release count at 1.
- RELEASE:
  - Count consecutive zero samples; any nonzero sample returns to HELD with no new pulse.
  - At DEBOUNCE zeros: clear key_held, go to SCAN at row+1 (wrapped).
- Width rule: key_code arithmetic is done in KW bits. index(pat) is the position of the single set bit.
- Reset is honoured in any state, including mid-DEBOUNCE, HELD or RELEASE. Reset values:
  - state SCAN, row 0, all counters 0, pat 0
  - r_sel = ~1 (row 0 low)
  - key_code 0, digits 0, key_valid 0, key_held 0, multi_err 0
- A press that began during reset is picked up as a fresh press on a later scan.

## Timing
- All outputs are registered.
- r_sel changes only on state/row transitions.
- No keys pressed: each row is driven exactly SETTLE cycles; scan period is ROWS*SETTLE cycles.
- First sample of row 0 occurs SETTLE-1 cycles after reset deasserts.
- Press latency: if the SCAN sample in cycle t is nonzero and col_sync stays equal to it:
  - DEBOUNCE-th matching sample is in cycle t+DEBOUNCE-1.
  - key_valid, key_code, digits and key_held update in cycle t+DEBOUNCE.
  - With DEBOUNCE=1, the update is in cycle t+1.
- key_valid and multi_err are exactly one cycle wide, at most one per press, and never both in the same cycle.
- Release: key_held falls DEBOUNCE cycles after the first zero sample in HELD, provided the zeros are uninterrupted. The first row-(row+1) SCAN cycle follows in the same cycle.

## Test plan
- Defaults, no keys, 40 cycles after reset: r_sel cycles 1110,1101,1011,0111 with 2 cycles each; key_valid, multi_err and key_held stay 0.
- Row 2 / col 1 (col_sync=0010 while r_sel=1011) held 30 cycles, then released: one key_valid, key_code=9, digits[3:0]=9; key_held falls 8 cycles after release; scan resumes at row 3.
- Presses 5 then 12, digits initially 0: after the first press digits={0,5}; after the second, digits={5,12} (newest in the low slice).
- Bounce: col_sync=0001 for 5 cycles then 0 on row 0: no pulses, scan continues at row 1.
- Release bounce: during RELEASE, zeros for 3 cycles, nonzero for 1, then zeros for 10: exactly one key_valid in total; key_held falls 8 cycles after the final zeros begin.
- col_sync=0110 stable on row 1: multi_err pulses once; key_code and digits are unchanged.
- Reset asserted mid-HELD: next cycle all outputs are at reset values with r_sel=1110.
- Instance with ROWS=3, COLS=5, DEBOUNCE=1: row 2 / col 4 gives key_code=14 one cycle after its sample.
